// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end (fetch and decode).
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; the head entry is visible combinationally.
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  fetch_entry_t            push_data_i,
    input  logic                    pop_i,
    output fetch_entry_t            head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale entries are never seen.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited reads to a
// 1-cycle instruction memory and queues {pc, instr} for the decoder.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              empty, full, pop, push, issue;
    fetch_entry_t      head, push_data;

    assign out_valid = !empty && !redirect && !RST;
    assign pop       = out_valid && out_ready;

    // Queued entries plus the word still on its way must leave room for one more.
    assign credit_used = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue       = !RST && !redirect && (credit_used < (CNT_W+1)'(DEPTH));

    assign push      = inflight_q && !kill_q && !redirect && !RST;
    assign push_data = '{pc: rsp_pc_q, instr: imem_rdata};

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_instr = (empty || RST) ? '0 : head.instr;
    assign out_pc    = (empty || RST) ? '0 : head.pc;

    mips_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .clr_i       (RST || redirect),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // A redirect cycle already drops the arriving word; kill covers any response
    // still outstanding behind it and clears after one cycle either way.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = issue;
        kill_d     = 1'b0;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            kill_d     = inflight_q || issue;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            rsp_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) assert (!(push && full && !pop));
    end

endmodule
